mod_7seg_scan: RTL
==================

# mod_7seg_scan

Time-multiplexed scan controller for a bank of common-select seven-segment digits that share one `mod_7seg` decoder. It latches a multi-digit BCD word, steps through the digits one at a time, and drives the shared decoder's `i_value` plus a one-hot digit select. A blanking gap between digits suppresses ghosting. Display updates are double-buffered and take effect only at frame boundaries, so a frame never mixes old and new digits.

## Interface
- `NUM_DIGITS`, default 4: number of digits scanned; must be ≥ 2.
- `DWELL_CYCLES`, default 50000: clock cycles each digit is lit; must be ≥ 1.
- `BLANK_CYCLES`, default 500: clock cycles with all digits off between lit digits; must be ≥ 1.
- `i_clk`  input  1: sole clock; all state updates on its rising edge.
- `i_rst_n`  input  1: reset, synchronous, active-low.
- `i_digits`  input  4*NUM_DIGITS: BCD digits; nibble k (bits 4k+3:4k) is digit k; digit 0 is least significant.
- `i_load`  input  1: single-cycle strobe; captures `i_digits` into the pending buffer.
- `o_nibble`  output  4: value for the shared decoder's `i_value`.
- `o_digit_sel`  output  NUM_DIGITS: one-hot, active-high digit enable; all-zero while blanking.
- `o_pending`  output  1: a captured word is waiting for the next frame boundary.
- `o_frame_start`  output  1: one-cycle pulse on the first lit cycle of digit 0.

## Operation
- Storage: pending buffer `pend`, active buffer `act` (both 4*NUM_DIGITS), digit index `idx` (width $clog2(NUM_DIGITS)), and a phase counter `cnt` sized for max(DWELL_CYCLES, BLANK_CYCLES).
- FSM states:
  - BLANK: `o_digit_sel`=0, `o_nibble`=4'hF. The decoder maps 4'hF to all segments off.
  - ON: `o_digit_sel`=1<<idx, `o_nibble`=act[idx].
- Transitions:
  - BLANK→ON when `cnt`==BLANK_CYCLES-1.
  - ON→BLANK when `cnt`==DWELL_CYCLES-1.
  - `cnt` clears on every transition.
- `idx` advances on each ON→BLANK edge and wraps from NUM_DIGITS-1 to 0.
- Frame boundary: the BLANK→ON edge with `idx`==0.
  - If `o_pending`=1 at that edge: `act`←`pend` and `o_pending` clears.
  - `o_frame_start` is asserted for the first ON cycle.
- `i_load`=1: `pend`←`i_digits`, `o_pending`←1 on the next edge.
  - A later load before the boundary overwrites `pend`; last load wins.
- `i_load` on the same edge as a frame boundary: `act`←old `pend`, `pend`←`i_digits`, `o_pending` stays 1.
- Nibbles > 9 pass through unchanged; the decoder blanks them.

## Timing
- Reset values (any cycle with `i_rst_n`=0):
  - state BLANK, `cnt`=0, `idx`=0.
  - `pend`=`act`=0, `o_pending`=0, `o_frame_start`=0.
  - `o_digit_sel`=0, `o_nibble`=4'hF.
- Reset mid-frame aborts the scan. The scan restarts at BLANK for digit 0 on the first cycle after release.
- After reset release, digit 0 is lit BLANK_CYCLES cycles later.
- Per-digit period: DWELL_CYCLES+BLANK_CYCLES.
- Frame period: NUM_DIGITS*(DWELL_CYCLES+BLANK_CYCLES).
- Outputs are registered (no combinational path from inputs). `o_pending` rises the cycle after `i_load`.
- Load-to-display latency: between 1 cycle and one full frame period.
- `o_digit_sel` never has more than one bit set. Two distinct digits are never lit in adjacent cycles.

## Configuration
- `MOD_7SEG_SCAN_LZB_EN` defined: leading-zero blanking is compiled in.
  - While in ON, a digit k>0 whose nibble and all higher nibbles of `act` are 0 drives `o_nibble`=4'hF.
  - Its select bit still asserts, so timing is unchanged.
  - Digit 0 always shows its value, so 0000 displays as "0".
- Macro undefined: every digit shows `act[k]` verbatim, including leading zeros.

## Test plan
All scenarios use NUM_DIGITS=4, DWELL_CYCLES=4, BLANK_CYCLES=2 (frame = 24 cycles).
- Reset then release: `o_digit_sel`=0 and `o_nibble`=F for 2 cycles. Then `o_digit_sel`=0001 for 4 cycles with `o_frame_start` on the first of them. Sel sequence 0010, 0100, 1000 repeats every 24 cycles.
- `i_load` with `i_digits`=16'h4321 mid-frame: `o_pending`=1 next cycle. At the next frame start, `o_nibble` shows 1,2,3,4 on sel 0001..1000 and `o_pending`=0.
- Loads 16'h1111 then 16'h9999 within one frame: the next frame shows only 9s.
- `i_load` (16'h5555) on the boundary edge while 16'h1234 is pending: the frame shows 1234, `o_pending` stays 1, and the following frame shows 5555.
- `i_rst_n`=0 during ON of digit 2 for 1 cycle: outputs go to reset values next cycle, and the scan restarts with 2 blank cycles, then digit 0 with `act`=0.
- Digits 16'h0070:
  - With `MOD_7SEG_SCAN_LZB_EN`: digits 3 and 2 output F, digit 1 outputs 7, digit 0 outputs 0.
  - Without the macro: digits 3..0 output 0,0,7,0.

Source files
------------

// File: rtl/mod_7seg_scan.sv
// -----------------------------------------------------------------------------
// mod_7seg_scan
//
// Time-multiplexed scan controller for a bank of common-select seven-segment
// digits that share one mod_7seg decoder. A multi-digit BCD word is captured
// into a pending buffer and copied to the active buffer only at a frame
// boundary, so one frame never mixes old and new digits. The controller
// lights the digits one at a time, with a blanking gap between them to stop
// ghosting.
//
// Optional feature macro: MOD_7SEG_SCAN_LZB_EN
//   When defined, leading zeros are blanked. While a digit k>0 is lit and
//   that nibble and every higher nibble of the active word are zero, the
//   digit shows 4'hF, which the decoder renders as all segments off. Its
//   select bit still asserts, so scan timing does not change. Digit 0 always
//   shows its value. When the macro is undefined, every digit shows its
//   nibble unchanged, including leading zeros.
//
// Parameters
//   NUM_DIGITS    number of digits scanned (>= 2)
//   DWELL_CYCLES  clock cycles each digit is lit (>= 1)
//   BLANK_CYCLES  clock cycles with all digits off between lit digits (>= 1)
//
// Ports
//   i_clk          clock; every state update happens on its rising edge
//   i_rst_n        synchronous reset, active low
//   i_digits       BCD word; nibble k (bits 4k+3:4k) is digit k, digit 0 is LSD
//   i_load         single-cycle strobe; captures i_digits into the pending buffer
//   o_nibble       value for the shared decoder's i_value (4'hF while blanking)
//   o_digit_sel    one-hot, active-high digit enable; all zero while blanking
//   o_pending      a captured word is waiting for the next frame boundary
//   o_frame_start  one-cycle pulse on the first lit cycle of digit 0
//   dbg_state      current scan FSM state (0 = BLANK, 1 = ON), for observation
//
// Handshake: i_load has no ready. Each cycle with i_load high is accepted
// unconditionally. The last load before a frame boundary is the one that is
// displayed. A load on the boundary edge itself is held for the following
// frame.
//
// Every output is a flop. The next-state values are decoded before the
// clock edge, so the select and nibble lines never glitch and never depend
// combinationally on the inputs.
// -----------------------------------------------------------------------------
module mod_7seg_scan #(
  parameter int NUM_DIGITS   = 4,
  parameter int DWELL_CYCLES = 50000,
  parameter int BLANK_CYCLES = 500
) (
  input  logic                    i_clk,
  input  logic                    i_rst_n,
  input  logic [4*NUM_DIGITS-1:0] i_digits,
  input  logic                    i_load,
  output logic [3:0]              o_nibble,
  output logic [NUM_DIGITS-1:0]   o_digit_sel,
  output logic                    o_pending,
  output logic                    o_frame_start,
  output logic [0:0]              dbg_state
);

  // ---------------------------------------------------------------------------
  // Sizing
  // ---------------------------------------------------------------------------
  localparam int MAX_CYC = (DWELL_CYCLES > BLANK_CYCLES) ? DWELL_CYCLES : BLANK_CYCLES;
  // The +1 keeps the counter at least 1 bit wide even when both phases are
  // a single cycle long.
  localparam int CW      = $clog2(MAX_CYC + 1);
  localparam int IW      = $clog2(NUM_DIGITS);
  localparam int WW      = 4 * NUM_DIGITS;

  localparam logic [CW-1:0] BLANK_LAST = CW'(BLANK_CYCLES - 1);
  localparam logic [CW-1:0] DWELL_LAST = CW'(DWELL_CYCLES - 1);
  localparam logic [IW-1:0] IDX_LAST   = IW'(NUM_DIGITS - 1);
  localparam logic [NUM_DIGITS-1:0] SEL_ONE = NUM_DIGITS'(1);

  // FSM encoding
  localparam logic [0:0] ST_BLANK = 1'b0;
  localparam logic [0:0] ST_ON    = 1'b1;

  // ---------------------------------------------------------------------------
  // State
  // ---------------------------------------------------------------------------
  logic [0:0]    state;
  logic [CW-1:0] cnt;
  logic [IW-1:0] idx;
  logic [WW-1:0] pend;
  logic [WW-1:0] act;
  logic          pending;

  // Next-state values
  logic [0:0]    nxt_state;
  logic [CW-1:0] nxt_cnt;
  logic [IW-1:0] nxt_idx;
  logic [WW-1:0] nxt_pend;
  logic [WW-1:0] nxt_act;
  logic          nxt_pending;

  // Next-output values, registered below
  logic [NUM_DIGITS-1:0] nxt_sel;
  logic [3:0]            nxt_nibble;

  // Phase-end and frame-boundary strobes
  logic blank_done;
  logic dwell_done;
  logic boundary;

  assign blank_done = (state == ST_BLANK) && (cnt == BLANK_LAST);
  assign dwell_done = (state == ST_ON)    && (cnt == DWELL_LAST);
  // The frame starts when digit 0 leaves its blanking gap.
  assign boundary   = blank_done && (idx == '0);

  // ---------------------------------------------------------------------------
  // Digit value seen by the decoder for digit k of word w
  // ---------------------------------------------------------------------------
  function automatic logic [3:0] digit_value(input logic [WW-1:0] w,
                                             input logic [IW-1:0] k);
    logic [3:0] v;
`ifdef MOD_7SEG_SCAN_LZB_EN
    logic [WW-1:0] upper;
    v     = w[{k, 2'b00} +: 4];
    // Shifting right by 4k leaves digit k and every higher digit. If all of
    // them are zero, digit k is a leading zero.
    upper = w >> {k, 2'b00};
    if ((k != '0) && (upper == '0)) begin
      v = 4'hF;
    end
`else
    v = w[{k, 2'b00} +: 4];
`endif
    return v;
  endfunction

  // ---------------------------------------------------------------------------
  // Next-state logic
  // ---------------------------------------------------------------------------
  always_comb begin
    nxt_state   = state;
    nxt_cnt     = cnt + CW'(1);
    nxt_idx     = idx;
    nxt_pend    = pend;
    nxt_act     = act;
    nxt_pending = pending;

    if (blank_done) begin
      nxt_state = ST_ON;
      nxt_cnt   = '0;
    end else if (dwell_done) begin
      nxt_state = ST_BLANK;
      nxt_cnt   = '0;
      nxt_idx   = (idx == IDX_LAST) ? '0 : idx + IW'(1);
    end

    // Buffer swap at the frame boundary. A load on the same edge is applied
    // after the swap, so act takes the old pend value and the new word stays
    // pending for the next frame.
    if (boundary) begin
      if (pending) begin
        nxt_act = pend;
      end
      nxt_pending = 1'b0;
    end
    if (i_load) begin
      nxt_pend    = i_digits;
      nxt_pending = 1'b1;
    end
  end

  // ---------------------------------------------------------------------------
  // Output decode from the next state
  // ---------------------------------------------------------------------------
  always_comb begin
    nxt_sel    = '0;
    nxt_nibble = 4'hF;
    if (nxt_state == ST_ON) begin
      nxt_sel    = SEL_ONE << nxt_idx;
      nxt_nibble = digit_value(nxt_act, nxt_idx);
    end
  end

  // ---------------------------------------------------------------------------
  // Registers
  // ---------------------------------------------------------------------------
  always_ff @(posedge i_clk) begin
    if (!i_rst_n) begin
      state         <= ST_BLANK;
      cnt           <= '0;
      idx           <= '0;
      pend          <= '0;
      act           <= '0;
      pending       <= 1'b0;
      o_digit_sel   <= '0;
      o_nibble      <= 4'hF;
      o_frame_start <= 1'b0;
    end else begin
      state         <= nxt_state;
      cnt           <= nxt_cnt;
      idx           <= nxt_idx;
      pend          <= nxt_pend;
      act           <= nxt_act;
      pending       <= nxt_pending;
      o_digit_sel   <= nxt_sel;
      o_nibble      <= nxt_nibble;
      // The boundary edge is the one that lights digit 0. The pulse is
      // therefore high for exactly the first lit cycle of the frame.
      o_frame_start <= boundary;
    end
  end

  assign o_pending = pending;
  assign dbg_state = state;

endmodule
